shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Controller that drives the shared 16-bit single-place shifter (shift codes 00 none, 01 left, 10 logical right, 11 arithmetic right) iteratively to perform multi-place shifts.
- Issues one shifter operation per cycle for N cycles and accumulates the result in an internal register.
- Sits between the datapath control FSM and the shifter instance.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, data width; must match the shifter width.
- CNT_W, 4, width of the shift-amount field; maximum amount is 2**CNT_W-1 (15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  WIDTH  operand, captured when start is accepted.
- op  input  2  shift code applied on every iteration; captured with start.
- amount  input  CNT_W  number of single-place shifts; captured with start.
- sh_in  output  WIDTH  operand driven to the shifter.
- sh_shift  output  2  shift code driven to the shifter.
- sh_out  input  WIDTH  combinational result returned by the shifter.
- out  output  WIDTH  final result; held until the next accepted start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when out becomes valid.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state = IDLE; acc, out and count = 0.
  - busy = 0, done = 0, sh_shift = 00.
  - Reset asserted mid-operation aborts the operation at the next edge; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, sh_shift = 00, sh_in = acc.
  - When start = 1 at an edge: acc <= in, op_r <= op, count <= amount.
  - Next state is DONE if amount == 0 or op == 00; otherwise SHIFT.
- SHIFT:
  - busy = 1, sh_in = acc, sh_shift = op_r.
  - Each edge: acc <= sh_out, count <= count-1.
  - When count == 1 at the edge, next state is DONE; otherwise stay in SHIFT.
- DONE:
  - out <= acc at the entry edge; done = 1 and busy = 1 for exactly one cycle.
  - Next state is IDLE unconditionally.
- Latency: done is high in the cycle following edge amount+1, counted from the edge that accepted start. amount = 0 or op = 00 gives done one edge after accept with out = in.
- start is ignored while busy = 1, including start in the DONE cycle. It is accepted on the edge after DONE (IDLE).
- in, op and amount may change freely after accept; the captured copies are used.
- out is registered and stable between done pulses. It is not updated during SHIFT.
- Arithmetic: the result is exactly `amount` compositions of the single-place shifter op.
  - 01: zero fill on the right.
  - 10: zero fill on the left.
  - 11: sign bit replicated on the left.
- sh_shift is 00 outside SHIFT, so the shifter is idle/transparent for other users.

Optional Feature:
- Macro: SHIFT_SEQ_EARLY_EXIT_EN.
- Defined: in SHIFT, if sh_out is a fixed point of op_r, the controller goes straight to DONE at that edge, with acc <= sh_out and count ignored.
  - Fixed point is all zeros for 01/10.
  - Fixed point is all zeros or all ones for 11.
  - out is identical to the full run; only latency shrinks.
- Undefined: always runs exactly `amount` SHIFT cycles.

Test Plan:
- in = 16'hF0F0, op = 01, amount = 4, start pulse -> busy for 5 cycles; done at edge 5; out = 16'h0F00. sh_shift = 01 for exactly 4 cycles.
- in = 16'h8000, op = 11, amount = 3 -> out = 16'hF000, done at edge 4. Same input with op = 10 -> out = 16'h1000.
- in = 16'hFFFF, op = 10, amount = 15 -> out = 16'h0001, done at edge 16. Next, amount = 0 with in = 16'h1234 -> out = 16'h1234, done at edge 1.
- Run op = 01, amount = 8; pulse start with different in while busy -> ignored, first result unchanged. Assert reset at edge 3 -> no done, busy = 0, out = 16'h0000 next cycle. A new start after reset works normally.
- in = 16'h0001, op = 10, amount = 8:
  - with SHIFT_SEQ_EARLY_EXIT_EN -> done at edge 2, out = 16'h0000.
  - without it -> done at edge 9, out = 16'h0000.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
// Bundles the control-side handshake (start/busy/done with operand, code and
// amount) together with the link to the shared single-place shifter.
//
// Signals:
//   start, in, op, amount  request from the datapath control FSM
//   out, busy, done        result and handshake back to the control FSM
//   sh_in, sh_shift        operand and shift code driven to the shifter
//   sh_out                 combinational result returned by the shifter
//
// Modports:
//   slave   the sequencer itself
//   master  its environment (control FSM plus shifter instance)
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] in;
  logic [1:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sh_in;
  logic [1:0]       sh_shift;
  logic [WIDTH-1:0] sh_out;

  modport slave (
    input  start, in, op, amount, sh_out,
    output out, busy, done, sh_in, sh_shift
  );

  modport master (
    output start, in, op, amount, sh_out,
    input  out, busy, done, sh_in, sh_shift
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Drives the shared 16-bit single-place shifter once per cycle to build a
// multi-place shift. Shift codes: 00 none, 01 left, 10 logical right,
// 11 arithmetic right. The running value lives in acc; out is updated only
// when the operation completes and is held until the next completion.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    shift_sequencer_if.slave (handshake + shifter link)
//
// Optional feature (macro SHIFT_SEQ_EARLY_EXIT_EN):
//   When defined, a SHIFT step whose result is a fixed point of the shift
//   code (all zeros, or all ones for arithmetic right) finishes immediately.
//   The result is unchanged; only latency shrinks. When undefined, exactly
//   `amount` SHIFT cycles are always executed.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] out_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       sh_shift_r;
  logic             early_exit;

  // The shifter always sees acc; sh_shift_r keeps it idle outside SHIFT so
  // other users of the shared shifter get a transparent path.
  assign bus.sh_in    = acc;
  assign bus.sh_shift = sh_shift_r;
  assign bus.out      = out_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Once the value stops changing under op_r, further iterations are
  // no-ops, so the remaining count can be skipped.
  always_comb begin
    early_exit = 1'b0;
    if (bus.sh_out == '0)
      early_exit = 1'b1;
    else if (op_r == 2'b11 && bus.sh_out == '1)
      early_exit = 1'b1;
  end
`else
  assign early_exit = 1'b0;
`endif

  // Single controller process. out is loaded on the edge that enters DONE
  // with the same value acc receives on that edge, so out is already valid
  // in the cycle where done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      op_r       <= 2'b00;
      count      <= '0;
      out_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sh_shift_r <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          sh_shift_r <= 2'b00;
          if (bus.start) begin
            acc    <= bus.in;
            op_r   <= bus.op;
            count  <= bus.amount;
            busy_r <= 1'b1;
            // Nothing to iterate: finish straight away with out = in.
            if (bus.amount == '0 || bus.op == 2'b00) begin
              state  <= DONE;
              out_r  <= bus.in;
              done_r <= 1'b1;
            end else begin
              state      <= SHIFT;
              sh_shift_r <= bus.op;
            end
          end
        end

        SHIFT: begin
          acc   <= bus.sh_out;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1) || early_exit) begin
            state      <= DONE;
            out_r      <= bus.sh_out;
            done_r     <= 1'b1;
            sh_shift_r <= 2'b00;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          sh_shift_r <= 2'b00;
        end
      endcase
    end
  end

endmodule
